// File: rtl/apa102_text_scroller.sv
// apa102_text_scroller
// Renders hex glyphs from an 8x8 font into a COLS x 8 window, scrolls the
// window left one column every FRAME_HOLD frames and streams it continuously
// to an APA102-style serpentine matrix (start frame, LED words, end frame).
module apa102_text_scroller #(
  parameter int COLS       = 8,
  parameter int FRAME_HOLD = 1,
  parameter bit SERPENTINE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        glyph_valid,
  input  logic [3:0]  glyph_code,
  output logic        glyph_ready,
  input  logic [31:0] fg_color,
  input  logic [31:0] bg_color,
  output logic        led_clk,
  output logic        led_data,
  output logic        frame_done
);

  localparam int N  = COLS * 8;
  localparam int E  = 1 + (N + 63) / 64;
  localparam int CW = $clog2(COLS);

  typedef enum logic [1:0] {SEG_START, SEG_LED, SEG_END} seg_t;

  // Frame position of the bit to be driven next
  seg_t          seg;
  logic [4:0]    bit_cnt;
  logic [CW-1:0] col_cnt;
  logic [2:0]    row_cnt;
  logic [2:0]    end_cnt;
  logic          phase;
  logic          active;
  logic          done_pend;

  // Colours latched at frame start
  logic [31:0]   fg_q;
  logic [31:0]   bg_q;

  // Display window (bit r of a column = row r) and glyph source
  logic [7:0]    window [COLS];
  logic          src_valid;
  logic [3:0]    src_glyph;
  logic [2:0]    src_idx;
  logic          hold_valid;
  logic [3:0]    hold_code;
  logic [7:0]    frame_cnt;

  logic          run;
  logic          frame_start;
  logic          last_bit;
  logic          step;
  logic          accept;
  logic [CW-1:0] col_phys;
  logic          pix_lit;
  logic [31:0]   led_word;
  logic          cur_bit;
  logic [63:0]   glyph_bits;
  logic [7:0]    src_col;

  // 8x8 hex font; byte 0 is the top row, bit 7 the leftmost column
  function automatic logic [63:0] font_rom(input logic [3:0] g);
    case (g)
      4'h0:    font_rom = 64'h7cc6cedef6e67c00;
      4'h1:    font_rom = 64'h307030303030fc00;
      4'h2:    font_rom = 64'h78cc0c3860ccfc00;
      4'h3:    font_rom = 64'h78cc0c380ccc7800;
      4'h4:    font_rom = 64'h1c3c6cccfe0c1e00;
      4'h5:    font_rom = 64'hfcc0f80c0ccc7800;
      4'h6:    font_rom = 64'h3860c0f8cccc7800;
      4'h7:    font_rom = 64'hfccc0c1830303000;
      4'h8:    font_rom = 64'h78cccc78cccc7800;
      4'h9:    font_rom = 64'h78cccc7c0c187000;
      4'ha:    font_rom = 64'h3078ccccfccccc00;
      4'hb:    font_rom = 64'hfc66667c6666fc00;
      4'hc:    font_rom = 64'h3c66c0c0c0663c00;
      4'hd:    font_rom = 64'hf86c6666666cf800;
      4'he:    font_rom = 64'hfe6268786862fe00;
      default: font_rom = 64'hfe6268786860f000;
    endcase
  endfunction

  assign glyph_ready = ~hold_valid;
  assign run         = active | enable;
  assign frame_start = run && (seg == SEG_START) && (bit_cnt == 5'd0) && !phase;
  assign last_bit    = phase && (seg == SEG_END) && (bit_cnt == 5'd31) &&
                       (end_cnt == 3'(E - 1));
  assign step        = frame_done && ((int'(frame_cnt) + 1) == FRAME_HOLD);
  assign accept      = glyph_valid && !hold_valid;

  // Even rows run right-to-left on a serpentine matrix
  assign col_phys = (SERPENTINE && !row_cnt[0]) ? (CW'(COLS - 1) - col_cnt) : col_cnt;
  assign pix_lit  = window[col_phys][row_cnt];
  assign led_word = pix_lit ? fg_q : bg_q;
  assign cur_bit  = (seg == SEG_LED) ? led_word[~bit_cnt] : 1'b0;

  // Column the source would feed into the window on the next scroll step
  always_comb begin
    glyph_bits = font_rom(src_glyph);
    src_col    = '0;
    for (int r = 0; r < 8; r++)
      src_col[r] = src_valid & glyph_bits[63 - 8 * r - int'(src_idx)];
  end

  // Bit serialiser: two clocks per bit, frames back-to-back while enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      seg        <= SEG_START;
      bit_cnt    <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      end_cnt    <= '0;
      phase      <= 1'b0;
      active     <= 1'b0;
      done_pend  <= 1'b0;
      frame_done <= 1'b0;
      led_clk    <= 1'b0;
      led_data   <= 1'b0;
    end else begin
      frame_done <= done_pend;
      done_pend  <= 1'b0;
      if (run) begin
        led_clk  <= phase;
        led_data <= cur_bit;
        phase    <= ~phase;
        if (phase) begin
          done_pend <= last_bit;
          active    <= last_bit ? enable : 1'b1;
          bit_cnt   <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            case (seg)
              SEG_START: begin
                seg     <= SEG_LED;
                col_cnt <= '0;
                row_cnt <= '0;
              end
              SEG_LED: begin
                if (col_cnt == CW'(COLS - 1)) begin
                  col_cnt <= '0;
                  if (row_cnt == 3'd7) begin
                    seg     <= SEG_END;
                    end_cnt <= '0;
                  end else begin
                    row_cnt <= row_cnt + 3'd1;
                  end
                end else begin
                  col_cnt <= col_cnt + CW'(1);
                end
              end
              default: begin
                if (end_cnt == 3'(E - 1)) seg <= SEG_START;
                else                       end_cnt <= end_cnt + 3'd1;
              end
            endcase
          end
        end else begin
          active <= 1'b1;
        end
      end else begin
        led_clk  <= 1'b0;
        led_data <= 1'b0;
      end
    end
  end

  // Colour sampling at the first bit of every frame
  always_ff @(posedge clk) begin
    if (frame_start) begin
      fg_q <= fg_color;
      bg_q <= bg_color;
    end
  end

  // Glyph handshake, frame counting, window scroll and column source
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_code  <= '0;
      src_valid  <= 1'b0;
      src_glyph  <= '0;
      src_idx    <= '0;
      frame_cnt  <= '0;
      for (int i = 0; i < COLS; i++) window[i] <= '0;
    end else begin
      if (accept) begin
        hold_valid <= 1'b1;
        hold_code  <= glyph_code;
      end
      if (frame_done) begin
        if (step) begin
          frame_cnt <= '0;
          for (int i = 0; i < COLS - 1; i++) window[i] <= window[i + 1];
          window[COLS - 1] <= src_col;
          if (src_valid && (src_idx != 3'd7)) begin
            src_idx <= src_idx + 3'd1;
          end else if (hold_valid) begin
            src_valid  <= 1'b1;
            src_glyph  <= hold_code;
            src_idx    <= '0;
            hold_valid <= 1'b0;
          end else begin
            src_valid <= 1'b0;
          end
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apa102_text_scroller.sv
// Testbench for apa102_text_scroller (COLS=8, FRAME_HOLD=1, SERPENTINE=1).
module tb_apa102_text_scroller;

  localparam int NW = 67;  // start word + 64 LED words + 2 end words
  localparam logic [31:0] BG  = 32'hf0070000;
  localparam logic [31:0] FG1 = 32'hf0000f00;
  localparam logic [31:0] FG2 = 32'he50000ff;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        glyph_valid;
  logic [3:0]  glyph_code;
  logic        glyph_ready;
  logic [31:0] fg_color;
  logic [31:0] bg_color;
  logic        led_clk;
  logic        led_data;
  logic        frame_done;

  apa102_text_scroller #(.COLS(8), .FRAME_HOLD(1), .SERPENTINE(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .glyph_valid (glyph_valid),
    .glyph_code  (glyph_code),
    .glyph_ready (glyph_ready),
    .fg_color    (fg_color),
    .bg_color    (bg_color),
    .led_clk     (led_clk),
    .led_data    (led_data),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          frame;
    int          wi;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] cap_words [NW];
  int          clk_err;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void add_vec(input string name, input int frame, input int wi,
                                  input logic [31:0] exp);
    vec_t v;
    v.name  = name;
    v.frame = frame;
    v.wi    = wi;
    v.exp   = exp;
    vecs.push_back(v);
  endfunction

  // Call at the falling edge of phase 0 of start bit 0; returns at the
  // falling edge of phase 0 of the next frame's first bit.
  task automatic capture_frame();
    clk_err = 0;
    for (int w = 0; w < NW; w++) begin
      for (int b = 0; b < 32; b++) begin
        if (led_clk !== 1'b0) clk_err++;
        @(negedge clk);
        if (led_clk !== 1'b1) clk_err++;
        cap_words[w][31 - b] = led_data;
        @(negedge clk);
      end
    end
  endtask

  task automatic check_frame(input int f);
    foreach (vecs[i])
      if (vecs[i].frame == f) chk(vecs[i].name, cap_words[vecs[i].wi], vecs[i].exp);
  endtask

  task automatic wait_fd(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) ok = 1'b1;
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  int idle_bad;
  int bg_bad;

  initial begin
    // frame 0: blank window
    add_vec("f0_start",   0, 0,  32'h0);
    add_vec("f0_p0",      0, 1,  BG);
    add_vec("f0_p1",      0, 2,  BG);
    add_vec("f0_p32",     0, 33, BG);
    add_vec("f0_p63",     0, 64, BG);
    add_vec("f0_end0",    0, 65, 32'h0);
    add_vec("f0_end1",    0, 66, 32'h0);
    // frame 9: glyph 1 fully in the window
    add_vec("f9_p2_bg",   9, 3,  BG);
    add_vec("f9_p4_fg",   9, 5,  FG1);
    add_vec("f9_p8_bg",   9, 9,  BG);
    add_vec("f9_p9_fg",   9, 10, FG1);
    add_vec("f9_p10_fg",  9, 11, FG1);
    add_vec("f9_p11_fg",  9, 12, FG1);
    add_vec("f9_p12_bg",  9, 13, BG);
    add_vec("f9_p48_bg",  9, 49, BG);
    add_vec("f9_p50_fg",  9, 51, FG1);
    add_vec("f9_p56_bg",  9, 57, BG);
    // frame 12: glyph 1 cols 3..7, two blanks, glyph 0 col 0; old fg
    add_vec("f12_p0_bg",  12, 1,  BG);
    add_vec("f12_p8_fg",  12, 9,  FG1);
    add_vec("f12_p13_bg", 12, 14, BG);
    add_vec("f12_p15_fg", 12, 16, FG1);
    add_vec("f12_p16_fg", 12, 17, FG1);
    // frame 13: one more column of glyph 0; new fg
    add_vec("f13_p1_bg",  13, 2,  BG);
    add_vec("f13_p8_bg",  13, 9,  BG);
    add_vec("f13_p14_fg", 13, 15, FG2);
    add_vec("f13_p15_fg", 13, 16, FG2);

    reset       = 1'b1;
    enable      = 1'b1;
    glyph_valid = 1'b0;
    glyph_code  = 4'h0;
    fg_color    = FG1;
    bg_color    = BG;
    repeat (3) @(negedge clk);
    chk("rst_led_clk",     {31'd0, led_clk},     32'd0);
    chk("rst_led_data",    {31'd0, led_data},    32'd0);
    chk("rst_frame_done",  {31'd0, frame_done},  32'd0);
    chk("rst_glyph_ready", {31'd0, glyph_ready}, 32'd1);

    reset = 1'b0;
    @(negedge clk);
    fork
      capture_frame();
      begin
        @(negedge clk);
        chk("ready_before_offer", {31'd0, glyph_ready}, 32'd1);
        glyph_valid = 1'b1;
        glyph_code  = 4'h1;
        @(negedge clk);
        chk("accept_1cyc", {31'd0, glyph_ready}, 32'd0);
        glyph_valid = 1'b0;
      end
    join
    chk("f0_frame_done", {31'd0, frame_done}, 32'd1);
    chk("f0_clk_phases", clk_err, 32'd0);
    check_frame(0);

    for (int f = 1; f <= 8; f++) wait_fd("fd_wait_1_8");
    capture_frame();
    chk("f9_frame_done", {31'd0, frame_done}, 32'd1);
    check_frame(9);

    // Hold glyph_valid high: code 0 then code 1
    glyph_valid = 1'b1;
    glyph_code  = 4'h0;
    @(negedge clk);
    chk("hold0_accept", {31'd0, glyph_ready}, 32'd0);
    glyph_code = 4'h1;
    wait_fd("fd_wait_10");
    chk("ready_low_until_step", {31'd0, glyph_ready}, 32'd0);
    @(negedge clk);
    chk("ready_reassert", {31'd0, glyph_ready}, 32'd1);
    @(negedge clk);
    chk("code1_accept", {31'd0, glyph_ready}, 32'd0);
    glyph_valid = 1'b0;
    wait_fd("fd_wait_11");
    chk("hold_waits_glyph0", {31'd0, glyph_ready}, 32'd0);

    // Mid-frame colour change
    fork
      capture_frame();
      begin
        repeat (1000) @(negedge clk);
        fg_color = FG2;
      end
    join
    check_frame(12);
    capture_frame();
    check_frame(13);

    // Drop enable mid-frame, then re-raise
    repeat (200) @(negedge clk);
    enable = 1'b0;
    wait_fd("fd_after_disable");
    idle_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (led_clk !== 1'b0 || led_data !== 1'b0) idle_bad++;
    end
    chk("idle_outputs_low", idle_bad, 32'd0);
    enable = 1'b1;
    @(negedge clk);
    capture_frame();
    chk("reenable_start", cap_words[0], 32'h0);
    chk("reenable_clk_phases", clk_err, 32'd0);
    chk("reenable_frame_done", {31'd0, frame_done}, 32'd1);

    // Reset in the middle of an LED word
    chk("ready_before_reset", {31'd0, glyph_ready}, 32'd0);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_led_clk",     {31'd0, led_clk},     32'd0);
    chk("midrst_led_data",    {31'd0, led_data},    32'd0);
    chk("midrst_glyph_ready", {31'd0, glyph_ready}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    capture_frame();
    bg_bad = 0;
    for (int w = 1; w <= 64; w++)
      if (cap_words[w] !== BG) bg_bad++;
    chk("postrst_all_bg", bg_bad, 32'd0);
    chk("postrst_start", cap_words[0], 32'h0);
    chk("postrst_frame_done", {31'd0, frame_done}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apa102_text_scroller.md
# apa102_text_scroller

Parametrised scrolling-text driver for an APA102-style serpentine LED matrix (clock + data, 32-bit LED frames). It accepts hex glyph codes over a valid/ready handshake and renders them from an internal 8x8 font ROM into a display window of COLS columns by 8 rows. It scrolls the window left one column every FRAME_HOLD frames and streams the matrix continuously. It sits between the character source and the LED matrix pins.

## Interface
- COLS, 8: matrix width in columns; legal range 8..32; ROWS is fixed at 8.
- FRAME_HOLD, 1: frames transmitted per scroll step; range 1..255.
- SERPENTINE, 1: 1 = even rows are wired right-to-left; 0 = all rows left-to-right.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  streaming enable.
- glyph_valid  in  1  glyph_code is offered.
- glyph_code  in  4  glyph index 0x0..0xF (hex digits; ROM contents in font8x8_hex.mem; glyph 0 = 7c c6 ce de f6 e6 7c 00, glyph 1 = 30 70 30 30 30 30 fc 00).
- glyph_ready  out  1  holding register is empty.
- fg_color  in  32  LED frame for lit pixels (111 + 5-bit brightness + B,G,R).
- bg_color  in  32  LED frame for unlit pixels.
- led_clk  out  1  strip clock.
- led_data  out  1  strip data, MSB first.
- frame_done  out  1  one-cycle pulse at end of each frame.

## Operation
- N = COLS*8 LEDs. E = 1 + ceil(N/64) end words. A frame is 32 zero bits (start), then N LED words, then 32*E zero bits (end). COLS=8 gives 2144 bits.
- Pixel p (0..N-1): r = p / COLS, c = p % COLS. If SERPENTINE=1 and r is even, c' = COLS-1-c; otherwise c' = c. The word for p is fg_color if window[c'] row r is set, else bg_color.
- Font row byte MSB is the leftmost column. Window column 0 is the leftmost.
- fg_color and bg_color are sampled into internal registers at the start of every frame. Changes mid-frame take effect the next frame.
- Handshake:
  - glyph_ready = !hold_valid.
  - A glyph is accepted when glyph_valid && glyph_ready. The accepted code enters the 1-entry holding register.
- Column source:
  - The source holds the current glyph plus a column index 0..7, or is blank.
  - On a scroll step, window[i] takes window[i+1], and window[COLS-1] takes the source column.
  - After column 7 is used, or if the source is blank, the source loads the holding register (clearing hold_valid) if it is valid; otherwise the source becomes blank and emits zero columns.
  - There is no bypass: a glyph accepted in the same cycle as a source load is not taken by that load.
- Scroll step: a frame counter counts completed frames. When it reaches FRAME_HOLD, the shift happens in the frame_done cycle and the counter clears. The shifted window is visible from the next frame.
- enable low: the current frame completes, then the block idles (led_clk=0, led_data=0). Scroll counting and handshake continue to operate. When enable returns high, the next frame begins with a full start frame.
- Reset values:
  - led_clk=0, led_data=0, frame_done=0, glyph_ready=1.
  - Window blank, source blank, frame counter 0, bit pointer at the start frame.
  - A reset mid-frame aborts the frame; the first frame after reset begins 1 cycle after reset deasserts (if enable=1).

## Timing
- Bit period is 2 clk cycles:
  - Phase 0: led_clk=0, led_data takes the new bit.
  - Phase 1: led_clk=1, data held (the strip samples on the rising edge).
- All outputs are registered. Frame length is 2*(32+32*N+32*E) cycles: 4288 for COLS=8.
- Frames are back-to-back with no gap while enable=1.
- frame_done is high in the cycle after phase 1 of the last end bit. That cycle is phase 0 of the next frame's first start bit.
- glyph_ready deasserts the cycle after an accept. It reasserts the cycle after the holding register is consumed.

## Test plan
- Reset, enable=1, no glyphs, bg_color=f0070000 -> start frame = 32 zeros, then 64 words of f0070000, then 64 zeros. frame_done pulses every 4288 cycles.
- Offer glyph 1 before the first frame_done (FRAME_HOLD=1, COLS=8, fg=f0000f00) -> accepted in 1 cycle. Frame 9 shows the full glyph:
  - p=2 (row 0, c'=5) is bg; p=4 (c'=3) is fg.
  - p=8..15 (row 1, unreversed) read 0x70 -> fg only at p=9,10,11.
- Hold glyph_valid with codes 0 then 1 -> code 0 is accepted. glyph_ready stays low until the first scroll step consumes code 0. Code 1 is accepted the next cycle and loads after glyph 0's 8th column.
- Change fg_color mid-frame -> the current frame keeps the old colour. The next frame uses the new colour.
- Drop enable mid-frame -> the frame completes with frame_done, then led_clk and led_data stay 0. Re-raise enable -> a new start frame begins with 32 zero bits.
- Assert reset mid-LED-word -> the next cycle has led_clk=0, led_data=0, glyph_ready=1. The following frames are all bg (window blank).
